// File: rtl/a_ctrl_pkg.sv
// Shared definitions for the host command decoder and read-back buffer.
// FSM states, header field positions and control-module ids.
package a_ctrl_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WR_DATA,
    S_RD,
    S_DISCARD,
    S_DONE
  } state_e;

  localparam int HDR_RW_BIT  = 15;
  localparam int HDR_ID_LSB  = 8;
  localparam int HDR_ID_MSB  = 11;
  localparam int HDR_LEN_LSB = 0;
  localparam int ID_W        = HDR_ID_MSB - HDR_ID_LSB + 1;

  localparam logic [ID_W-1:0] MOD_ID_SET_VERIF = 4'd0;
  localparam logic [ID_W-1:0] MOD_ID_MAX       = 4'd15;

endpackage

// File: rtl/a_rdback_hold.sv
// Single-entry read-back buffer with the host transmit handshake.
// A word leaves on the first cycle the transmitter is ready.
module a_rdback_hold
  import a_ctrl_pkg::*;
(
  input  logic              clk_ref,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic              cap_i,
  input  logic [WORD_W-1:0] cap_data_i,
  input  logic              tx_ready_i,
  output logic              tx_dv_o,
  output logic [WORD_W-1:0] tx_data_o,
  output logic              full_o,
  output logic              drop_o
);

  logic              full_q, full_d;
  logic [WORD_W-1:0] hold_q, hold_d;
  logic              emit;

  assign emit      = en_i && full_q && tx_ready_i;
  assign drop_o    = en_i && cap_i && full_q && !tx_ready_i;
  assign tx_dv_o   = emit;
  assign tx_data_o = hold_q;
  assign full_o    = full_q;

  // Slot frees on emit and may refill in the same cycle; flushed when idle.
  always_comb begin
    full_d = full_q;
    hold_d = hold_q;
    if (!en_i) begin
      full_d = 1'b0;
    end else begin
      if (emit) full_d = 1'b0;
      if (cap_i && !drop_o) begin
        full_d = 1'b1;
        hold_d = cap_data_i;
      end
    end
  end

  // Hold register state.
  always_ff @(posedge clk_ref) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      hold_q <= '0;
    end else begin
      full_q <= full_d;
      hold_q <= hold_d;
    end
  end

endmodule

// File: rtl/a_cmd_decoder.sv
// Host command decoder driving the verification control modules.
// Define CMD_TIMEOUT_EN to abort stalled transactions after TIMEOUT cycles.
module a_cmd_decoder
  import a_ctrl_pkg::*;
#(
  parameter int N_MOD     = 4,
  parameter int HDR_LEN_W = 8,
  parameter int TIMEOUT   = 1024
) (
  input  logic                    clk_ref,
  input  logic                    rst_n,
  input  logic                    rx_dv_i,
  input  logic [WORD_W-1:0]       rx_data_i,
  input  logic                    tx_ready_i,
  output logic                    tx_dv_o,
  output logic [WORD_W-1:0]       tx_data_o,
  output logic [N_MOD-1:0]        select_o,
  output logic                    r_w_o,
  output logic                    dv_o,
  output logic [WORD_W-1:0]       data_o,
  output logic                    busy_o,
  input  logic [N_MOD-1:0]        rd_dv_i,
  input  logic [WORD_W*N_MOD-1:0] rd_data_i,
  output logic                    err_o
);

  localparam int CNT_W = HDR_LEN_W + 1;

  state_e              state_q, state_d;
  logic                is_wr_q, is_wr_d;
  logic [CNT_W-1:0]    len_q, len_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    cnt_inc;
  logic [N_MOD-1:0]    sel_q, sel_d;
  logic                rw_q, rw_d;
  logic                dv_q, dv_d;
  logic [WORD_W-1:0]   data_q, data_d;
  logic                err_q, err_d;

  logic                hdr_rw;
  logic [ID_W-1:0]     hdr_id;
  logic [HDR_LEN_W-1:0] hdr_len_raw;
  logic [CNT_W-1:0]    hdr_len;
  logic [N_MOD-1:0]    hdr_sel;
  logic                hdr_ok;
  logic                rd_hit;
  logic [WORD_W-1:0]   rd_word;
  logic                in_rd;
  logic                hold_full;
  logic                hold_drop;

`ifdef CMD_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] to_q, to_d;
`endif

  assign hdr_rw      = rx_data_i[HDR_RW_BIT];
  assign hdr_id      = rx_data_i[HDR_ID_MSB:HDR_ID_LSB];
  assign hdr_len_raw = rx_data_i[HDR_LEN_LSB +: HDR_LEN_W];
  assign hdr_len     = {(hdr_len_raw == '0), hdr_len_raw};
  assign hdr_ok      = int'(hdr_id) < N_MOD;
  assign cnt_inc     = cnt_q + CNT_W'(1);
  assign in_rd       = (state_q == S_RD);
  assign rd_hit      = in_rd && |(rd_dv_i & sel_q);

  // Header id to one-hot select and selected read-back slice.
  always_comb begin
    hdr_sel = '0;
    rd_word = '0;
    for (int k = 0; k < N_MOD; k++) begin
      hdr_sel[k] = (int'(hdr_id) == k);
      if (sel_q[k]) rd_word = rd_data_i[WORD_W*k +: WORD_W];
    end
  end

  a_rdback_hold u_hold (
    .clk_ref    (clk_ref),
    .rst_n      (rst_n),
    .en_i       (in_rd),
    .cap_i      (rd_hit),
    .cap_data_i (rd_word),
    .tx_ready_i (tx_ready_i),
    .tx_dv_o    (tx_dv_o),
    .tx_data_o  (tx_data_o),
    .full_o     (hold_full),
    .drop_o     (hold_drop)
  );

  // Transaction sequencing and next values of the registered outputs.
  always_comb begin
    state_d = state_q;
    is_wr_d = is_wr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    rw_d    = rw_q;
    dv_d    = 1'b0;
    data_d  = data_q;
    err_d   = hold_drop;
    unique case (state_q)
      S_IDLE: begin
        if (rx_dv_i) begin
          len_d   = hdr_len;
          cnt_d   = '0;
          is_wr_d = hdr_rw;
          if (hdr_ok) begin
            state_d = S_ARM;
            sel_d   = hdr_sel;
            rw_d    = hdr_rw;
          end else begin
            err_d   = 1'b1;
            state_d = hdr_rw ? S_DISCARD : S_IDLE;
          end
        end
      end
      S_ARM: begin
        state_d = is_wr_q ? S_WR_DATA : S_RD;
      end
      S_WR_DATA: begin
        if (rx_dv_i) begin
          dv_d   = 1'b1;
          data_d = rx_data_i;
          cnt_d  = cnt_inc;
          if (cnt_inc == len_q) begin
            state_d = S_DONE;
            sel_d   = '0;
            rw_d    = 1'b0;
          end
        end
      end
      S_RD: begin
        if (tx_dv_o) begin
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) begin
            state_d = S_DONE;
            sel_d   = '0;
            rw_d    = 1'b0;
          end
        end
      end
      S_DISCARD: begin
        if (rx_dv_i) begin
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) state_d = S_IDLE;
        end
      end
      S_DONE: begin
        sel_d   = '0;
        rw_d    = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
`ifdef CMD_TIMEOUT_EN
    to_d = '0;
    if (state_q == S_WR_DATA || in_rd || state_q == S_DISCARD) begin
      if (rx_dv_i || rd_hit) begin
        to_d = '0;
      end else if (to_q == TO_W'(TIMEOUT - 1)) begin
        err_d   = 1'b1;
        state_d = S_DONE;
        sel_d   = '0;
        rw_d    = 1'b0;
      end else begin
        to_d = to_q + TO_W'(1);
      end
    end
`endif
  end

  // FSM state, counters and registered outputs.
  always_ff @(posedge clk_ref) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      is_wr_q <= 1'b0;
      len_q   <= '0;
      cnt_q   <= '0;
      sel_q   <= '0;
      rw_q    <= 1'b0;
      dv_q    <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      is_wr_q <= is_wr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      rw_q    <= rw_d;
      dv_q    <= dv_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

`ifdef CMD_TIMEOUT_EN
  // Idle-cycle counter for the stall abort.
  always_ff @(posedge clk_ref) begin
    if (!rst_n) to_q <= '0;
    else        to_q <= to_d;
  end
`endif

  assign select_o = sel_q;
  assign r_w_o    = rw_q;
  assign dv_o     = dv_q;
  assign data_o   = data_q;
  assign err_o    = err_q;
  assign busy_o   = in_rd && (!tx_ready_i || hold_full);

endmodule
